b205_io_loopback_ctrl: RTL and testbench



---
 rtl/b205_io_pkg.sv | 25 ++
 rtl/lfsr12.sv | 23 ++
 rtl/b205_io_loopback_ctrl.sv | 158 +++++++++++++++
 tb/tb_b205_io_loopback_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/b205_io_pkg.sv
// rtl/b205_io_pkg.sv - shared types and constants for the B205 IO loopback trainer
package b205_io_pkg;

  localparam int SAMPLE_W = 12;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SEARCH = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // x^12 + x^11 + x^10 + x^4 + 1: feedback from state bits 11, 10, 9 and 3
  localparam sample_t LFSR_SEED = 12'h001;
  localparam sample_t LFSR_TAPS = 12'hE08;

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0
  function automatic sample_t lfsr_next(input sample_t s);
    return {s[SAMPLE_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr12.sv
// rtl/lfsr12.sv - 12-bit Fibonacci LFSR pattern source with synchronous reseed
module lfsr12
  import b205_io_pkg::*;
(
  input  logic    radio_clk,
  input  logic    reset_n,
  input  logic    en,
  input  logic    reseed,
  output sample_t lfsr_state
);

  // Reseed has priority so a new training run always starts from the seed
  always_ff @(posedge radio_clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_state <= LFSR_SEED;
    end else if (reseed) begin
      lfsr_state <= LFSR_SEED;
    end else if (en) begin
      lfsr_state <= lfsr_next(lfsr_state);
    end
  end

endmodule

// File: rtl/b205_io_loopback_ctrl.sv
// rtl/b205_io_loopback_ctrl.sv - AD9361 digital loopback latency search and sample checker
module b205_io_loopback_ctrl
  import b205_io_pkg::*;
#(
  parameter int MAX_LAT   = 15,
  parameter int LOCK_LEN  = 8,
  parameter int CHECK_LEN = 1024
) (
  input  logic        radio_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] tx_i_user,
  input  logic [11:0] tx_q_user,
  output logic [11:0] tx_i0,
  output logic [11:0] tx_q0,
  input  logic [11:0] rx_i0,
  input  logic [11:0] rx_q0,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  latency,
  output logic [15:0] err_count
);

  localparam logic [3:0]  MAX_L      = 4'(MAX_LAT);
  localparam logic [15:0] FLUSH_LAST = 16'(MAX_LAT);
  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_LEN - 1);
  localparam logic [15:0] CHECK_LAST = 16'(CHECK_LEN - 1);

  state_t            state;
  sample_t           lfsr_q;
  logic [14:0][11:0] hist_r;
  logic [15:0][11:0] taps;
  logic [3:0]        cand;
  logic [3:0]        sel;
  logic [15:0]       cnt;
  logic [11:0]       exp_i;
  logic              match;
  logic [15:0]       err_nxt;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  lfsr12 u_lfsr (
    .radio_clk  (radio_clk),
    .reset_n    (reset_n),
    .en         (busy),
    .reseed     (start && !abort && (state == S_IDLE)),
    .lfsr_state (lfsr_q)
  );

  // TX mux register: user samples when idle, pattern (I, ~I) while training
  always_ff @(posedge radio_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_i0 <= '0;
      tx_q0 <= '0;
    end else if (busy) begin
      tx_i0 <= lfsr_q;
      tx_q0 <= ~lfsr_q;
    end else begin
      tx_i0 <= tx_i_user;
      tx_q0 <= tx_q_user;
    end
  end

  // History of transmitted I; hist_r[k] is tx_i0 from k+1 cycles ago
  always_ff @(posedge radio_clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_r <= '0;
    end else begin
      hist_r <= {hist_r[13:0], tx_i0};
    end
  end

  // Expected sample for the latency under test and the I/Q match decision
  always_comb begin
    taps    = {hist_r, tx_i0};
    sel     = (state == S_CHECK) ? latency : cand;
    exp_i   = taps[sel];
    match   = (rx_i0 == exp_i) && (rx_q0 == ~exp_i);
    err_nxt = (!match && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
  end

  // Training sequencer; cnt is reused as flush, match-run and check counter
  always_ff @(posedge radio_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cand      <= '0;
      cnt       <= '0;
      pass      <= 1'b0;
      latency   <= '0;
      err_count <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FLUSH;
            cnt       <= '0;
            pass      <= 1'b0;
            latency   <= '0;
            err_count <= '0;
          end
        end
        S_FLUSH: begin
          // Fill the whole history window with pattern before judging any candidate
          if (cnt == FLUSH_LAST) begin
            state <= S_SEARCH;
            cand  <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SEARCH: begin
          if (match) begin
            if (cnt == LOCK_LAST) begin
              latency <= cand;
              cnt     <= '0;
              state   <= S_CHECK;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            cnt <= '0;
            if (cand == MAX_L) begin
              state     <= S_DONE;
              pass      <= 1'b0;
              latency   <= '0;
              err_count <= '0;
            end else begin
              cand <= cand + 4'd1;
            end
          end
        end
        S_CHECK: begin
          err_count <= err_nxt;
          if (cnt == CHECK_LAST) begin
            state <= S_DONE;
            pass  <= (err_nxt == 16'd0);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b205_io_loopback_ctrl.sv
// tb/tb_b205_io_loopback_ctrl.sv - scoreboard bench for the loopback trainer
module tb_b205_io_loopback_ctrl;

  localparam int MAX_LAT   = 15;
  localparam int LOCK_LEN  = 8;
  localparam int CHECK_LEN = 1024;

  logic        radio_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic [11:0] tx_i_user = '0;
  logic [11:0] tx_q_user = '0;
  logic [11:0] tx_i0, tx_q0, rx_i0, rx_q0;
  logic        busy, done, pass;
  logic [3:0]  latency;
  logic [15:0] err_count;

  typedef struct {
    int pass;
    int lat;
    int err;
    int dur;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   passes   = 0;
  int   done_cnt = 0;

  int   chan_d    = 1;
  bit   chan_swap = 1'b0;
  bit   corrupt   = 1'b0;
  logic [11:0] pipe_i [0:31];
  logic [11:0] pipe_q [0:31];
  int   pat [0:15];

  b205_io_loopback_ctrl #(
    .MAX_LAT   (MAX_LAT),
    .LOCK_LEN  (LOCK_LEN),
    .CHECK_LEN (CHECK_LEN)
  ) dut (
    .radio_clk (radio_clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .tx_i_user (tx_i_user),
    .tx_q_user (tx_q_user),
    .tx_i0     (tx_i0),
    .tx_q0     (tx_q0),
    .rx_i0     (rx_i0),
    .rx_q0     (rx_q0),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .latency   (latency),
    .err_count (err_count)
  );

  always #5 radio_clk = ~radio_clk;

  // Loopback channel: pipe_x[k] holds the tx sample from k+1 cycles ago
  always @(posedge radio_clk) begin
    pipe_i[0] <= tx_i0;
    pipe_q[0] <= tx_q0;
    for (int k = 1; k < 32; k++) begin
      pipe_i[k] <= pipe_i[k-1];
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_comb begin
    rx_i0 = (chan_swap ? pipe_q[chan_d-1] : pipe_i[chan_d-1]) ^ (corrupt ? 12'h080 : 12'h000);
    rx_q0 = chan_swap ? pipe_i[chan_d-1] : pipe_q[chan_d-1];
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Pattern as a bit stream with feedback taps at delays 12, 11, 10 and 4;
  // word k carries stream bit (k - j) in bit position j
  function automatic void build_pattern();
    int bs [0:40];
    for (int i = 0; i < 41; i++) bs[i] = 0;
    bs[11] = 1;
    for (int m = 12; m < 41; m++) bs[m] = bs[m-12] ^ bs[m-11] ^ bs[m-10] ^ bs[m-4];
    for (int k = 0; k < 16; k++) begin
      pat[k] = 0;
      for (int j = 0; j < 12; j++) pat[k] = pat[k] | (bs[k + 11 - j] << j);
    end
  endfunction

  // Outcome of one training run from the channel description alone
  function automatic exp_t model(input int d, input bit sw, input int nc);
    exp_t e;
    if (sw) e = '{0, 0, 0, 0};
    else if (d > MAX_LAT) e = '{0, 0, 0, 2 * (MAX_LAT + 1) + 1};
    else e = '{int'(nc == 0), d, nc, (MAX_LAT + 1) + d + LOCK_LEN + CHECK_LEN + 1};
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation
  initial begin : monitor
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge radio_clk);
      if (!reset_n || !busy) bcnt = 0;
      else bcnt++;
      if (done) begin
        done_cnt++;
        chk("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("result_pass", pass, e.pass);
          chk("result_latency", latency, e.lat);
          chk("result_err_count", err_count, e.err);
          if (e.dur > 0) chk("duration", bcnt, e.dur);
        end
      end
    end
  end

  task automatic train(input int d, input bit sw, input int nc,
                       input int abort_at, input int reset_at, input bit pat_chk);
    int b, c1, c2, dn;
    chan_d    = d;
    chan_swap = sw;
    tx_i_user = 12'($urandom);
    tx_q_user = tx_i_user ^ 12'h5A5;
    repeat (30) @(negedge radio_clk);
    c1 = $urandom_range(400, 100);
    c2 = $urandom_range(900, 500);
    if (abort_at == 0 && reset_at == 0) sb.push_back(model(d, sw, nc));
    start = 1'b1;
    @(negedge radio_clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    b = 1;
    while (busy && b < 4000) begin
      corrupt = (nc >= 1 && b == c1) || (nc >= 2 && b == c2);
      start   = (b == 50);
      if (pat_chk && b >= 2 && b <= 17) begin
        chk("pattern_i", tx_i0, pat[b-2]);
        chk("pattern_q", tx_q0, (~pat[b-2]) & 12'hFFF);
      end
      if (b == abort_at) begin
        abort = 1'b1;
        dn    = done_cnt;
        @(negedge radio_clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pass", pass, 0);
        chk("abort_latency_held", latency, d);
        chk("abort_err_held", err_count, 0);
        @(negedge radio_clk);
        chk("abort_tx_i", tx_i0, tx_i_user);
        chk("abort_tx_q", tx_q0, tx_q_user);
        repeat (5) @(negedge radio_clk);
        chk("abort_no_done", done_cnt, dn);
        return;
      end
      if (b == reset_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_tx_i0", tx_i0, 0);
        chk("rst_tx_q0", tx_q0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_latency", latency, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge radio_clk);
        reset_n = 1'b1;
        @(negedge radio_clk);
        chk("rst_passthrough", tx_i0, tx_i_user);
        return;
      end
      @(negedge radio_clk);
      b++;
    end
    start   = 1'b0;
    corrupt = 1'b0;
    chk("trial_finished", b < 4000, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    build_pattern();
    #1;
    chk("reset_tx_i0", tx_i0, 0);
    chk("reset_tx_q0", tx_q0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_latency", latency, 0);
    chk("reset_err_count", err_count, 0);
    repeat (3) @(negedge radio_clk);
    reset_n = 1'b1;

    tx_i_user = 12'hABC;
    tx_q_user = 12'h123;
    @(negedge radio_clk);
    chk("idle_tx_i", tx_i0, 12'hABC);
    chk("idle_tx_q", tx_q0, 12'h123);
    chk("idle_busy", busy, 0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge radio_clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    train(3, 1'b0, 0, 0, 0, 1'b1);
    train(20, 1'b0, 0, 0, 0, 1'b0);
    train(5, 1'b0, 2, 0, 0, 1'b0);
    train(4, 1'b1, 0, 0, 0, 1'b0);
    train(5, 1'b0, 0, 200, 0, 1'b0);
    train(5, 1'b0, 0, 0, 0, 1'b0);
    train(20, 1'b0, 0, 0, 20, 1'b0);
    repeat (6) train($urandom_range(22, 1), $urandom_range(5, 0) == 0,
                     $urandom_range(2, 0), 0, 0, 1'b0);

    repeat (30) @(negedge radio_clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
